// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bus between a numeric source and one BCD converter.
// The source (time/counter logic) is the master; the converter is the slave.
interface bin_to_bcd_seq_if #(
    parameter int IN_WIDTH = 6,
    parameter int DIGITS   = 2
);
    logic                  start;
    logic [IN_WIDTH-1:0]   number;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [DIGITS*4-1:0]   bcd;

    modport master (output start, number, input  busy, done, err, bcd);
    modport slave  (input  start, number, output busy, done, err, bcd);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter.
// One input bit is consumed per cycle; bcd/err only change on the FINISH cycle,
// so the renderer never sees partially converted digits.

// Per-digit correction: a digit of 5..9 would overflow past 9 on the next
// shift, so it is pre-biased by 3.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_seq #(
    parameter int          IN_WIDTH  = 6,
    parameter int          DIGITS    = 2,
    parameter int unsigned MAX_VALUE = 59
) (
    input  logic          clk,
    input  logic          rst_n,
    bin_to_bcd_seq_if.slave bus
);
    localparam int BW = DIGITS * 4;
    localparam int CW = $clog2(IN_WIDTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]          state;
    logic [IN_WIDTH-1:0] sreg;
    logic [IN_WIDTH-1:0] cap;
    logic [BW-1:0]       scratch;
    logic [BW-1:0]       adj;
    logic [CW-1:0]       cnt;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [BW-1:0]       bcd_q;
    logic                over;

    // One corrector per digit; the top-digit carry is dropped by construction.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_add3 u_add3 (.d(scratch[g*4 +: 4]), .q(adj[g*4 +: 4]));
    end

    // Range check is unsigned and wide enough that MAX_VALUE never truncates.
    assign over = 33'(cap) > 33'(MAX_VALUE);

    // Conversion FSM: capture, IN_WIDTH shift steps, then publish result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            cap     <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sreg    <= bus.number;
                        cap     <= bus.number;
                        scratch <= '0;
                        cnt     <= CW'(IN_WIDTH);
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {adj[BW-2:0], sreg[IN_WIDTH-1]};
                    sreg    <= sreg << 1;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FINISH;
                end
                FINISH: begin
                    if (over) begin
                        bcd_q <= '1;
                        err_q <= 1'b1;
                    end else begin
                        bcd_q <= scratch;
                        err_q <= 1'b0;
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.bcd  = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a default 6-bit/2-digit instance and a wide
// 16-bit/5-digit instance, checked against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.IN_WIDTH(6),  .DIGITS(2)) if0 ();
    bin_to_bcd_seq_if #(.IN_WIDTH(16), .DIGITS(5)) if1 ();

    bin_to_bcd_seq #(.IN_WIDTH(6), .DIGITS(2), .MAX_VALUE(59)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(5), .MAX_VALUE(65535)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected result from plain decimal arithmetic.
    task automatic model_bcd(input int w, input logic [31:0] v,
                             output logic [63:0] q, output logic e);
        int digits = (w == 0) ? 2 : 5;
        longint unsigned maxv = (w == 0) ? 59 : 65535;
        longint unsigned x = v;
        q = '0;
        e = (x > maxv);
        if (e) q = (64'd1 << (4 * digits)) - 64'd1;
        else
            for (int d = 0; d < digits; d++) begin
                q |= 64'(x % 10) << (4 * d);
                x /= 10;
            end
    endtask

    task automatic set_start(input int w, input logic s);
        if (w == 0) if0.start = s; else if1.start = s;
    endtask

    task automatic set_num(input int w, input logic [31:0] v);
        if (w == 0) if0.number = v[5:0]; else if1.number = v[15:0];
    endtask

    task automatic sample(input int w, output logic b, output logic d,
                          output logic e, output logic [63:0] q);
        if (w == 0) begin b = if0.busy; d = if0.done; e = if0.err; q = 64'(if0.bcd); end
        else        begin b = if1.busy; d = if1.done; e = if1.err; q = 64'(if1.bcd); end
    endtask

    // One conversion, called on a negedge. Optionally fires an extra start
    // (ign_at) or changes number (chg_at) mid-conversion; -1 disables.
    task automatic conv(input int w, input logic [31:0] v,
                        input int ign_at, input logic [31:0] ign_v,
                        input int chg_at, input logic [31:0] chg_v);
        logic b, d, e, exp_e;
        logic [63:0] q, exp_q;
        int lat = -1, nb = 0;
        int exp_lat = (w == 0) ? 7 : 17;
        model_bcd(w, v, exp_q, exp_e);
        set_num(w, v);
        set_start(w, 1'b1);
        @(posedge clk);
        for (int i = 0; i < exp_lat + 6; i++) begin
            @(negedge clk);
            if (i == 0) set_start(w, 1'b0);
            if (i == ign_at) begin set_num(w, ign_v); set_start(w, 1'b1); end
            if (i == ign_at + 1) set_start(w, 1'b0);
            if (i == chg_at) set_num(w, chg_v);
            sample(w, b, d, e, q);
            if (b) nb++;
            if (d) begin lat = i; break; end
        end
        chk($sformatf("w%0d bcd(%0d)", w, v), q, exp_q);
        chk($sformatf("w%0d err(%0d)", w, v), 64'(e), 64'(exp_e));
        chk($sformatf("w%0d latency(%0d)", w, v), 64'(lat), 64'(exp_lat));
        chk($sformatf("w%0d busy_cycles(%0d)", w, v), 64'(nb), 64'(exp_lat));
    endtask

    // Both instances must stay quiet: no done, no busy.
    task automatic idle_chk(input int n, input string tag);
        int nd = 0, nb = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (if0.done || if1.done) nd++;
            if (if0.busy || if1.busy) nb++;
        end
        chk({tag, " done"}, 64'(nd), 64'd0);
        chk({tag, " busy"}, 64'(nb), 64'd0);
    endtask

    initial begin
        logic b, d, e;
        logic [63:0] q;
        if0.start = 1'b0; if0.number = '0;
        if1.start = 1'b0; if1.number = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sample(w, b, d, e, q);
            chk($sformatf("w%0d rst bcd", w), q, 64'd0);
            chk($sformatf("w%0d rst err", w), 64'(e), 64'd0);
            chk($sformatf("w%0d rst busy", w), 64'(b), 64'd0);
            chk($sformatf("w%0d rst done", w), 64'(d), 64'd0);
        end
        rst_n = 1'b1;
        idle_chk(10, "idle after reset");
        chk("idle bcd", 64'(if0.bcd), 64'd0);

        // Legal sweep, back-to-back starts right after each done.
        for (int v = 0; v < 60; v++) conv(0, v, -1, 0, -1, 0);

        // Out of range, then recover.
        conv(0, 60, -1, 0, -1, 0);
        conv(0, 63, -1, 0, -1, 0);
        conv(0, 5,  -1, 0, -1, 0);

        // Start while busy is dropped; number change mid-flight is ignored.
        conv(0, 12, 2, 45, 4, 33);
        idle_chk(6, "no queued start");
        chk("held bcd 12", 64'(if0.bcd), 64'h12);

        // Reset in the middle of SHIFT.
        set_num(0, 47);
        set_start(0, 1'b1);
        @(posedge clk);
        @(negedge clk); set_start(0, 1'b0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        sample(0, b, d, e, q);
        chk("midrst busy", 64'(b), 64'd0);
        chk("midrst bcd", q, 64'd0);
        chk("midrst err", 64'(e), 64'd0);
        chk("midrst done", 64'(d), 64'd0);
        rst_n = 1'b1;
        idle_chk(10, "after midrst");
        conv(0, 21, -1, 0, -1, 0);

        // Random conversions on the default instance (includes error range).
        for (int n = 0; n < 30; n++) conv(0, $urandom_range(0, 63), -1, 0, -1, 0);

        // Wide instance.
        conv(1, 65535, -1, 0, -1, 0);
        conv(1, 1000,  -1, 0, -1, 0);
        conv(1, 0,     -1, 0, -1, 0);
        for (int n = 0; n < 20; n++) conv(1, $urandom_range(0, 65535), -1, 0, -1, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
